// File: rtl/cordic_input_prep.sv
// CORDIC front-end: decodes the function select, range-reduces rotation angles by +/-pi
// and loads the core's initial vector. Optional reduction enabled by CORDIC_RANGE_REDUCE_EN.
module cordic_input_prep #(
  parameter int               WIDTH    = 32,
  parameter int               MAX_ITER = 16,
  parameter logic [WIDTH-1:0] ONE      = 32'h00010000,
  parameter logic [WIDTH-1:0] PI       = 32'h0003243F,
  parameter logic [WIDTH-1:0] HALF_PI  = 32'h00019220
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       select,
  input  logic [WIDTH-1:0] value_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] x0,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] z0,
  output logic [3:0]       sel_out,
  output logic             neg,
  output logic             range_err,
  output logic             out_valid,
  input  logic             out_ready
);

`ifdef CORDIC_RANGE_REDUCE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, REDUCE = 2'd1, OUT = 2'd2} state_t;
`else
  typedef enum logic {IDLE = 1'b0, OUT = 1'b1} state_t;
`endif

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] x0_r, x0_nxt_s;
  logic [WIDTH-1:0] y0_r, y0_nxt_s;
  logic [WIDTH-1:0] z0_r, z0_nxt_s;
  logic [3:0]       sel_r, sel_nxt_s;
  logic             out_valid_r, out_valid_nxt_s;

  assign in_ready  = (state_r == IDLE) && !rst;
  assign x0        = x0_r;
  assign y0        = y0_r;
  assign z0        = z0_r;
  assign sel_out   = sel_r;
  assign out_valid = out_valid_r;

`ifdef CORDIC_RANGE_REDUCE_EN
  localparam int CNT_W = $clog2(MAX_ITER + 1);
  localparam logic signed [WIDTH-1:0] POS_HALF_PI = HALF_PI;
  localparam logic signed [WIDTH-1:0] NEG_HALF_PI = {WIDTH{1'b0}} - HALF_PI;

  logic signed [WIDTH-1:0] z_r, z_nxt_s;
  logic [CNT_W-1:0]        count_r, count_nxt_s;
  logic                    neg_r, neg_nxt_s;
  logic                    err_r, err_nxt_s;
  logic                    above_s, below_s, is_tan_s;

  assign neg       = neg_r;
  assign range_err = err_r;
  assign above_s   = (z_r > POS_HALF_PI);
  assign below_s   = (z_r < NEG_HALF_PI);
  // tan only when neither sin nor cos has priority
  assign is_tan_s  = !sel_r[0] && !sel_r[1] && sel_r[2];

  // Next-state and next-output decode, one reduction step per REDUCE cycle
  always_comb begin
    state_nxt_s     = state_r;
    x0_nxt_s        = x0_r;
    y0_nxt_s        = y0_r;
    z0_nxt_s        = z0_r;
    sel_nxt_s       = sel_r;
    out_valid_nxt_s = out_valid_r;
    z_nxt_s         = z_r;
    count_nxt_s     = count_r;
    neg_nxt_s       = neg_r;
    err_nxt_s       = err_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          sel_nxt_s   = select;
          neg_nxt_s   = 1'b0;
          count_nxt_s = {CNT_W{1'b0}};
          if (select[2:0] == 3'b000) begin
            x0_nxt_s        = ONE;
            y0_nxt_s        = value_in;
            z0_nxt_s        = {WIDTH{1'b0}};
            err_nxt_s       = 1'b0;
            out_valid_nxt_s = 1'b1;
            state_nxt_s     = OUT;
          end else begin
            z_nxt_s     = value_in;
            state_nxt_s = REDUCE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REDUCE: begin
        if ((above_s || below_s) && (count_r != CNT_W'(MAX_ITER))) begin
          z_nxt_s     = above_s ? (z_r - PI) : (z_r + PI);
          neg_nxt_s   = !neg_r;
          count_nxt_s = count_r + CNT_W'(1);
        end else begin
          x0_nxt_s        = ONE;
          y0_nxt_s        = {WIDTH{1'b0}};
          z0_nxt_s        = z_r;
          neg_nxt_s       = is_tan_s ? 1'b0 : neg_r;
          err_nxt_s       = above_s || below_s;
          out_valid_nxt_s = 1'b1;
          state_nxt_s     = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          out_valid_nxt_s = 1'b0;
          state_nxt_s     = IDLE;
        end else begin
          state_nxt_s = OUT;
        end
      end
      default: begin
        out_valid_nxt_s = 1'b0;
        state_nxt_s     = IDLE;
      end
    endcase
  end

  // Reduction working registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_r     <= {WIDTH{1'b0}};
      count_r <= {CNT_W{1'b0}};
      neg_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      z_r     <= z_nxt_s;
      count_r <= count_nxt_s;
      neg_r   <= neg_nxt_s;
      err_r   <= err_nxt_s;
    end
  end
`else
  assign neg       = 1'b0;
  assign range_err = 1'b0;

  // Next-state and next-output decode; rotation angles load unreduced
  always_comb begin
    state_nxt_s     = state_r;
    x0_nxt_s        = x0_r;
    y0_nxt_s        = y0_r;
    z0_nxt_s        = z0_r;
    sel_nxt_s       = sel_r;
    out_valid_nxt_s = out_valid_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          sel_nxt_s       = select;
          x0_nxt_s        = ONE;
          out_valid_nxt_s = 1'b1;
          state_nxt_s     = OUT;
          if (select[2:0] == 3'b000) begin
            y0_nxt_s = value_in;
            z0_nxt_s = {WIDTH{1'b0}};
          end else begin
            y0_nxt_s = {WIDTH{1'b0}};
            z0_nxt_s = value_in;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      OUT: begin
        if (out_ready) begin
          out_valid_nxt_s = 1'b0;
          state_nxt_s     = IDLE;
        end else begin
          state_nxt_s = OUT;
        end
      end
      default: begin
        out_valid_nxt_s = 1'b0;
        state_nxt_s     = IDLE;
      end
    endcase
  end
`endif

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      x0_r        <= {WIDTH{1'b0}};
      y0_r        <= {WIDTH{1'b0}};
      z0_r        <= {WIDTH{1'b0}};
      sel_r       <= 4'b0000;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      x0_r        <= x0_nxt_s;
      y0_r        <= y0_nxt_s;
      z0_r        <= z0_nxt_s;
      sel_r       <= sel_nxt_s;
      out_valid_r <= out_valid_nxt_s;
    end
  end

endmodule
